// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 33-cycle fixed latency for every funct3 value.
// Define MULDIV_DIVIDE_EN to build the restoring divider; without it, divide opcodes return 0.
module muldiv_unit #(
  parameter bit RESULT_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        accept;
  logic        last_iter;
  logic [4:0]  count;
  logic [2:0]  op;
  logic        neg_res;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [63:0] acc_next;

  logic        a_signed;
  logic        b_signed;
  logic        init_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] init_acc;
  logic [31:0] init_opnd;

  logic [32:0] mul_sum;
  logic [63:0] prod_fix;
  logic [31:0] mul_res;
  logic [31:0] div_res;
  logic [31:0] final_res;

`ifdef MULDIV_DIVIDE_EN
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
`endif

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (state == CALC) && (count == 5'd31);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count == 5'd31) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        state_next = start ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The sign flag records whether the magnitude result needs negating at the end.
  // A signed divide by zero keeps the all-ones quotient, so it never negates.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    init_neg = 1'b0;
    case (funct3)
      3'b001: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        init_neg = A[31] ^ B[31];
      end
      3'b010: begin
        a_signed = 1'b1;
        init_neg = A[31];
      end
      3'b100: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        init_neg = (A[31] ^ B[31]) & (B != 32'd0);
      end
      3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        init_neg = A[31];
      end
      default: ;
    endcase
  end

  assign a_mag     = (a_signed && A[31]) ? (~A + 32'd1) : A;
  assign b_mag     = (b_signed && B[31]) ? (~B + 32'd1) : B;
  assign init_acc  = funct3[2] ? {32'd0, a_mag} : {32'd0, b_mag};
  assign init_opnd = funct3[2] ? b_mag : a_mag;

  // acc holds {high, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    acc_next = {mul_sum, acc[31:1]};
`ifdef MULDIV_DIVIDE_EN
    div_shift = acc[63:31];
    div_diff  = div_shift[31:0] - opnd;
    if (op[2]) begin
      if (div_shift >= {1'b0, opnd}) begin
        acc_next = {div_diff, acc[30:0], 1'b1};
      end else begin
        acc_next = {div_shift[31:0], acc[30:0], 1'b0};
      end
    end
`else
    if (op[2]) begin
      acc_next = acc;
    end
`endif
  end

  always_comb begin
    prod_fix = neg_res ? (~acc_next + 64'd1) : acc_next;
    mul_res  = (op[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
`ifdef MULDIV_DIVIDE_EN
    quo_fix  = neg_res ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    rem_fix  = neg_res ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
    div_res  = op[1] ? rem_fix : quo_fix;
`else
    div_res  = 32'd0;
`endif
    final_res = op[2] ? div_res : mul_res;
  end

  // Operands are latched on acceptance so later input changes cannot disturb the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 5'd0;
      op      <= 3'd0;
      neg_res <= 1'b0;
      opnd    <= 32'd0;
      acc     <= 64'd0;
      result  <= 32'd0;
    end else if (accept) begin
      count   <= 5'd0;
      op      <= funct3;
      neg_res <= init_neg;
      opnd    <= init_opnd;
      acc     <= init_acc;
      result  <= 32'd0;
    end else if (state == CALC) begin
      count <= count + 5'd1;
      acc   <= acc_next;
      if (last_iter) begin
        result <= final_res;
      end
    end else if ((state == DONE) && !RESULT_HOLD) begin
      result <= 32'd0;
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter RESULT_HOLD, default 1: when 1, result holds after done until the next accepted start; when 0, result clears to 0 the cycle after done.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request an operation; sampled at a rising edge of clk.
REQ-005 The module SHALL have port funct3, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The module SHALL have ports A and B, input, 32 bits each: operands from the execute-stage operand muxes (same sources as the ALU).
REQ-007 The module SHALL have port busy, output, 1 bit: operation in progress; the pipeline stalls while high.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse; result is valid in that cycle.
REQ-009 The module SHALL have port result, output, 32 bits: muldiv result feeding the EX/MEM writeback mux beside ALUOut.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 The FSM SHALL transition as follows:
- IDLE to CALC on start.
- CALC to DONE after 32 iterations.
- DONE to CALC on start, otherwise DONE to IDLE.
REQ-012 The unit SHALL capture start, funct3, A and B at edge k only in IDLE or DONE; start during CALC SHALL be ignored with no effect on the operation in progress.
REQ-013 Timing for a start accepted at edge k:
- busy SHALL be high after edges k through k+31.
- done SHALL be high only after edge k+32.
- The fixed latency of 33 cycles SHALL apply to every funct3 value, including the special cases.
REQ-014 Multiply SHALL be a 32-iteration shift-add on operand magnitudes, followed by sign correction per funct3:
- MULH: A and B signed.
- MULHSU: A signed, B unsigned.
- MULHU: both unsigned.
- MUL returns product bits [31:0]; the MULH variants return bits [63:32].
REQ-015 Divide SHALL be a 32-iteration restoring divide on magnitudes:
- DIV: quotient sign = sign(A) XOR sign(B).
- REM: remainder sign = sign(A).
- Both truncate toward zero.
REQ-016 Divide by zero (B=0) SHALL give quotient 0xFFFFFFFF for both DIV and DIVU, and remainder = A.
REQ-017 Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0.
REQ-018 Start accepted in the DONE cycle SHALL begin a new operation with no idle gap; done SHALL deassert and busy SHALL assert after that edge.
REQ-019 Operand changes on A, B and funct3 after capture SHALL NOT affect the operation in progress.

Reset
REQ-020 Assertion of reset SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- busy=0, done=0, result=0;
- iteration counter and internal accumulators to 0.
REQ-021 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow.
REQ-022 The first start SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-023 With macro MULDIV_DIVIDE_EN defined, funct3 values 100-111 SHALL operate per REQ-015..REQ-017.
REQ-024 Without MULDIV_DIVIDE_EN, the divide datapath SHALL be absent. funct3 values 100-111 SHALL still follow REQ-013 timing and return result=0. Multiply behaviour SHALL be unchanged.

Verification
REQ-025 The bench SHALL cover MUL with A=7, B=6, start at edge 0: busy high for 32 cycles, then done pulse after edge 32 with result=0x0000002A.
REQ-026 The bench SHALL cover high-half multiplies with A=B=0xFFFFFFFF: MULH gives 0x00000000, MULHU gives 0xFFFFFFFE, MULHSU gives 0xFFFFFFFF.
REQ-027 The bench SHALL cover signed divide with A=0xFFFFFFF9 (-7), B=2: DIV gives 0xFFFFFFFD, REM gives 0xFFFFFFFF.
REQ-028 The bench SHALL cover the divide special cases:
- DIVU with A=0x1234, B=0 gives 0xFFFFFFFF; REMU gives 0x00001234.
- DIV with A=0x80000000, B=0xFFFFFFFF gives 0x80000000.
REQ-029 The bench SHALL cover start pulsed at cycle 10 of a MUL 3*5: the extra start is ignored, a single done occurs, and result=0x0000000F.
REQ-030 The bench SHALL cover reset asserted at cycle 15 of a DIVU: busy, done and result go to 0 with no clock edge; no done follows; a new MUL 2*2 gives 0x00000004 after 33 cycles.
